// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 state encodings, error codes and timing defaults
// for the host transmitter and the keyboard receiver.
package ps2_host_tx_pkg;
   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, RECOVER} state_t;
   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_FIRST = 2'b01;
   localparam logic [1:0] ERR_XFER  = 2'b10;
   localparam logic [1:0] ERR_ACK   = 2'b11;
   localparam int CLK_HZ_DEF = 50_000_000;
   localparam int INHIBIT_US = 120;
   localparam int FIRST_MS   = 15;
   localparam int XFER_MS    = 2;
   localparam int FILTER_DEF = 8;
   localparam int CNT_W      = 20;
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction
endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// ps2_host_tx_line_filter: 2-FF synchroniser, FILTER-sample debounce and a
// one-cycle strobe when the filtered level falls.
module ps2_host_tx_line_filter #(
   parameter int FILTER = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_line,
   output logic o_level,
   output logic o_fall
);
   localparam int CW = $clog2(FILTER + 1);
   logic          r_s1, r_s2, r_level, r_fall;
   logic [CW-1:0] r_cnt;
   logic          w_flip;
   // the level only follows after FILTER consecutive samples that disagree with it
   assign w_flip  = (r_s2 != r_level) && (r_cnt == CW'(FILTER - 1));
   assign o_level = r_level;
   assign o_fall  = r_fall;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_s1    <= 1'b1;
         r_s2    <= 1'b1;
         r_level <= 1'b1;
         r_fall  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= i_line;
         r_s2    <= r_s1;
         r_cnt   <= (r_s2 == r_level || w_flip) ? '0 : r_cnt + 1'b1;
         r_level <= w_flip ? r_s2 : r_level;
         r_fall  <= w_flip & ~r_s2;
      end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send,
// 11-bit frame clocked by the device, ACK check) with first-clock and transfer timeouts.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int CLK_HZ      = CLK_HZ_DEF,
   parameter int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US,
   parameter int FIRST_CYC   = CLK_HZ / 1000 * FIRST_MS,
   parameter int XFER_CYC    = CLK_HZ / 1000 * XFER_MS,
   parameter int FILTER      = FILTER_DEF
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   output logic [1:0] tx_err_code,
   output logic       rx_hold,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);
   localparam logic [CNT_W-1:0] INH_LOAD   = CNT_W'(INHIBIT_CYC - 1);
   localparam logic [CNT_W-1:0] FIRST_LOAD = CNT_W'(FIRST_CYC - 1);
   localparam logic [CNT_W-1:0] XFER_LOAD  = CNT_W'(XFER_CYC - 1);
   state_t           r_state, w_state;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic [9:0]       r_shift, w_shift;
   logic [3:0]       r_bit, w_bit;
   logic [1:0]       r_code, w_code, w_fcode;
   logic             r_busy, w_busy, r_done, w_done, r_err, w_err;
   logic             r_clk_oe, w_clk_oe, r_dat_oe, w_dat_oe;
   logic             w_fail, w_timeout, w_clk_q, w_clk_fall, w_dat_q, w_unused_dat_fall;
   ps2_host_tx_line_filter #(.FILTER(FILTER)) u_clk (
      .i_clk(CLOCK_50), .i_rst_n(RESET_N), .i_line(ps2_clk_i),
      .o_level(w_clk_q), .o_fall(w_clk_fall)
   );
   ps2_host_tx_line_filter #(.FILTER(FILTER)) u_dat (
      .i_clk(CLOCK_50), .i_rst_n(RESET_N), .i_line(ps2_dat_i),
      .o_level(w_dat_q), .o_fall(w_unused_dat_fall)
   );
   assign w_timeout   = r_cnt == '0;
   assign tx_busy     = r_busy;
   assign rx_hold     = r_busy;
   assign tx_done     = r_done;
   assign tx_error    = r_err;
   assign tx_err_code = r_code;
   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_dat_oe  = r_dat_oe;
   // each state checks its timeout before the fall, so a simultaneous timeout wins
   always_comb begin
      w_state  = r_state;
      w_cnt    = w_timeout ? r_cnt : r_cnt - 1'b1;
      w_shift  = r_shift;
      w_bit    = r_bit;
      w_busy   = r_state != IDLE;
      w_done   = 1'b0;
      w_err    = 1'b0;
      w_code   = r_code;
      w_clk_oe = r_clk_oe;
      w_dat_oe = r_dat_oe;
      w_fail   = 1'b0;
      w_fcode  = ERR_XFER;
      case (r_state)
         IDLE: if (tx_start && !r_busy) begin
            w_state  = INHIBIT;
            w_cnt    = INH_LOAD;
            w_shift  = {1'b1, odd_parity(tx_data), tx_data};
            w_code   = ERR_NONE;
            w_busy   = 1'b1;
            w_clk_oe = 1'b1;
         end
         INHIBIT: if (w_timeout) begin
            w_state  = REQ;
            w_cnt    = FIRST_LOAD;
            w_clk_oe = 1'b0;
            w_dat_oe = 1'b1;
         end
         REQ: if (w_timeout) begin
            w_fail  = 1'b1;
            w_fcode = ERR_FIRST;
         end else if (w_clk_fall) begin
            w_state  = SHIFT;
            w_cnt    = XFER_LOAD;
            w_bit    = '0;
            w_dat_oe = ~r_shift[0];
            w_shift  = r_shift >> 1;
         end
         SHIFT: if (w_timeout) begin
            w_fail = 1'b1;
         end else if (w_clk_fall) begin
            w_dat_oe = ~r_shift[0];
            w_shift  = r_shift >> 1;
            w_bit    = r_bit + 1'b1;
            w_state  = (r_bit == 4'd8) ? ACK : SHIFT;
         end
         ACK: if (w_timeout) begin
            w_fail = 1'b1;
         end else if (w_clk_fall) begin
            w_fail  = w_dat_q;
            w_fcode = ERR_ACK;
            w_state = RECOVER;
         end
         RECOVER: if (w_timeout) begin
            w_fail = 1'b1;
         end else if (w_clk_q && w_dat_q) begin
            w_done  = 1'b1;
            w_state = IDLE;
         end
         default: w_state = IDLE;
      endcase
      if (w_fail) begin
         w_state  = IDLE;
         w_err    = 1'b1;
         w_code   = w_fcode;
         w_clk_oe = 1'b0;
         w_dat_oe = 1'b0;
      end
   end
   always_ff @(posedge CLOCK_50 or negedge RESET_N)
      if (!RESET_N) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_shift  <= '0;
         r_bit    <= '0;
         r_code   <= ERR_NONE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_clk_oe <= 1'b0;
         r_dat_oe <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_shift  <= w_shift;
         r_bit    <= w_bit;
         r_code   <= w_code;
         r_busy   <= w_busy;
         r_done   <= w_done;
         r_err    <= w_err;
         r_clk_oe <= w_clk_oe;
         r_dat_oe <= w_dat_oe;
      end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: open-drain PS/2 device model clocking frames out of the host
// transmitter; scaled timing parameters keep runs short.
module tb_ps2_host_tx;
   localparam int PER   = 20;
   localparam int INH   = 60;
   localparam int FIRST = 2000;
   localparam int XFER  = 3000;
   localparam int FILT  = 8;
   localparam int H     = 40;
   localparam int LIMIT = INH + FIRST + XFER + 1000;
   typedef struct {
      logic [7:0] d;
      int         nf;
      bit         ack;
      bit         gl;
      bit         poke;
      logic [1:0] e_code;
      bit         e_done;
   } vec_t;
   logic       clk = 1'b0, rst_n, tx_start, tx_busy, tx_done, tx_error, rx_hold;
   logic       ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe, dev_clk_lo, dev_dat_lo;
   logic [7:0] tx_data;
   logic [1:0] tx_err_code;
   int         total = 0, bad = 0, dev_falls = 0;
   time        t_start, t_fall, t_err;
   vec_t       tbl[8];
   always #(PER / 2) clk = ~clk;
   assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_lo);
   assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_lo);
   ps2_host_tx #(.CLK_HZ(50_000_000), .INHIBIT_CYC(INH), .FIRST_CYC(FIRST), .XFER_CYC(XFER), .FILTER(FILT)) dut (
      .CLOCK_50(clk), .RESET_N(rst_n), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error), .tx_err_code(tx_err_code),
      .rx_hold(rx_hold), .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
      .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {1'b1, ones % 2 == 0, d, 1'b0};
   endfunction
   function automatic logic [1:0] code_of(input int nf, input bit ack);
      if (nf == 0) return 2'b01;
      if (nf < 11) return 2'b10;
      return ack ? 2'b00 : 2'b11;
   endfunction
   // device: samples DAT mid-high before each fall, ACKs before fall 11 if asked
   task automatic device(input int nf, input bit ack, input bit gl, output logic [10:0] got, output int inh);
      int w = 0;
      got = 'x;
      inh = 0;
      while (!ps2_clk_oe && w < 20) begin @(negedge clk); w++; end
      while (ps2_clk_oe && inh < 4 * INH) begin @(negedge clk); inh++; end
      wait_n(30);
      for (int k = 1; k <= nf; k++) begin
         wait_n(16);
         got[k-1] = ps2_dat_i;
         if (k == 11 && ack) dev_dat_lo = 1'b1;
         wait_n(6);
         if (gl) begin dev_clk_lo = 1'b1; wait_n(4); dev_clk_lo = 1'b0; end
         else wait_n(4);
         wait_n(14);
         dev_clk_lo = 1'b1;
         if (k == 1) t_fall = $time;
         dev_falls = k;
         wait_n(H);
         dev_clk_lo = 1'b0;
      end
      wait_n(H);
      dev_dat_lo = 1'b0;
      wait_n(20);
   endtask
   task automatic run_txn(input logic [7:0] d, input int nf, input bit ack, input bit gl, input bit poke,
                          input logic [1:0] e_code, input bit e_done, input string tag);
      logic [10:0] got;
      logic [1:0]  code = '0, mid = '0;
      int          inh, nd = 0, ne = 0, extra = 0, ones = 0;
      bit          fin = 0;
      @(negedge clk);
      tx_data = d;
      tx_start = 1'b1;
      t_start = $time;
      dev_falls = 0;
      fork
         device(nf, ack, gl, got, inh);
         begin
            for (int i = 0; i < LIMIT && !fin; i++) begin
               @(negedge clk);
               tx_start = poke && i == 100;
               if (poke && i == 100) tx_data = ~d;
               if (i == 50) mid = {tx_busy, rx_hold};
               if (tx_done || tx_error) begin
                  fin = 1;
                  nd = int'(tx_done);
                  ne = int'(tx_error);
                  code = tx_err_code;
                  t_err = $time;
                  tx_start = 1'b1;
               end
            end
            @(negedge clk);
            tx_start = 1'b0;
            repeat (6) begin @(negedge clk); extra += int'(tx_done) + int'(tx_error); end
         end
      join
      chk({tag, " finished"}, 32'(fin), 1);
      chk({tag, " busy mid"}, 32'(mid), 2'b11);
      chk({tag, " done"}, nd, 32'(e_done));
      chk({tag, " error"}, ne, 32'(!e_done));
      chk({tag, " code"}, 32'(code), 32'(e_code));
      chk({tag, " extra pulses"}, extra, 0);
      chk({tag, " idle after"}, {tx_busy, rx_hold, ps2_clk_oe, ps2_dat_oe}, 0);
      chk({tag, " code held"}, 32'(tx_err_code), 32'(e_code));
      chk({tag, " inhibit len"}, 32'(inh >= INH && inh <= INH + 1), 1);
      if (nf == 11) begin
         chk({tag, " frame"}, 32'(got), 32'(frame_of(d)));
         for (int i = 1; i < 10; i++) ones += int'(got[i]);
         chk({tag, " odd ones"}, ones % 2, 1);
      end
      if (nf == 0) chk({tag, " first timeout"}, 32'((t_err - t_start) / PER - 1), INH + FIRST);
      else if (nf < 11) chk({tag, " xfer timeout"},
         32'((t_err - t_fall) / PER >= XFER && (t_err - t_fall) / PER <= XFER + FILT + 4), 1);
   endtask
   initial begin
      #(PER * 90000);
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end
   initial begin
      logic [10:0] g;
      int          inh, nf;
      bit          ack;
      logic [7:0]  d;
      tbl = '{
         '{8'hED, 11, 1, 0, 0, 2'b00, 1},
         '{8'h01, 11, 1, 0, 0, 2'b00, 1},
         '{8'hFF, 11, 1, 0, 1, 2'b00, 1},
         '{8'h00,  0, 1, 0, 0, 2'b01, 0},
         '{8'hA5, 11, 0, 0, 0, 2'b11, 0},
         '{8'h3C,  4, 1, 0, 0, 2'b10, 0},
         '{8'h5A, 11, 1, 1, 0, 2'b00, 1},
         '{8'h80, 11, 1, 0, 0, 2'b00, 1}
      };
      rst_n = 1'b0;
      tx_start = 1'b0;
      tx_data = 8'h00;
      dev_clk_lo = 1'b0;
      dev_dat_lo = 1'b0;
      wait_n(3);
      chk("reset outputs", {tx_busy, tx_done, tx_error, tx_err_code, rx_hold, ps2_clk_oe, ps2_dat_oe}, 0);
      rst_n = 1'b1;
      wait_n(30);
      chk("idle after reset", {tx_busy, ps2_clk_oe, ps2_dat_oe}, 0);
      for (int i = 0; i < 8; i++)
         run_txn(tbl[i].d, tbl[i].nf, tbl[i].ack, tbl[i].gl, tbl[i].poke, tbl[i].e_code, tbl[i].e_done, "vec");
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         nf = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 10)) : 11;
         ack = $urandom_range(0, 3) != 0;
         run_txn(d, nf, ack, 1'($urandom_range(0, 1)), 0, code_of(nf, ack), nf == 11 && ack, "rand");
      end
      @(negedge clk);
      tx_data = 8'h00;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      wait_n(10);
      chk("inhibit before reset", {ps2_clk_oe, tx_busy}, 2'b11);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("async reset inhibit", {ps2_clk_oe, ps2_dat_oe, tx_busy}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_n(30);
      dev_falls = 0;
      fork
         device(4, 1, 0, g, inh);
         begin
            @(negedge clk);
            tx_data = 8'h00;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            for (int w = 0; w < 3000 && dev_falls < 3; w++) @(negedge clk);
            chk("reached shift", 32'(dev_falls >= 3), 1);
            wait_n(20);
            chk("shift before reset", {ps2_dat_oe, tx_busy}, 2'b11);
            @(posedge clk);
            #3 rst_n = 1'b0;
            #1 chk("async reset shift", {ps2_clk_oe, ps2_dat_oe, tx_busy, rx_hold}, 0);
         end
      join
      @(negedge clk);
      rst_n = 1'b1;
      wait_n(30);
      run_txn(8'hED, 11, 1, 0, 1, 2'b00, 1, "after reset");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
